// File: rtl/convolve_pkg.sv
// convolve_pkg: shared word/accumulator widths, FSM states and output saturation
package convolve_pkg;
   localparam int W = 16;
   localparam int ACC_W = 40;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   function automatic logic [W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] s;
      s = acc >>> 15;
      return s > 40'sd32767 ? 16'h7fff : s < -40'sd32768 ? 16'h8000 : s[W-1:0];
   endfunction
endpackage

// File: rtl/conv_mac_tree.sv
// conv_mac_tree: one output sample from N_TAPS parallel Q1.15 products, summed and saturated
module conv_mac_tree import convolve_pkg::*; #(
   parameter int N_TAPS = 20
) (
   input  logic [N_TAPS*W-1:0] coeff,
   input  logic [N_TAPS*W-1:0] window,
   output logic [W-1:0]        y
);
   logic signed [2*W-1:0] prod [N_TAPS];
   logic signed [ACC_W-1:0] acc;
   for (genvar k = 0; k < N_TAPS; k++) begin : g_mul
      assign prod[k] = $signed(coeff[k*W +: W]) * $signed(window[k*W +: W]);
   end
   always_comb begin
      acc = '0;
      for (int k = 0; k < N_TAPS; k++) acc = acc + ACC_W'(prod[k]);
   end
   assign y = sat16(acc);
endmodule

// File: rtl/convolve.sv
// convolve: full linear convolution of a captured coefficient vector and signal block,
// one output sample per clock into a flattened result bus
module convolve import convolve_pkg::*; #(
   parameter int N_TAPS = 20,
   parameter int N_SAMPLES = 2401,
   localparam int N_OUT = N_TAPS + N_SAMPLES - 1
) (
   input  logic                   clk,
   input  logic                   load,
   input  logic [N_TAPS*W-1:0]    filter_coeff,
   input  logic [N_SAMPLES*W-1:0] signal_in,
   output logic [N_OUT*W-1:0]     conv_result,
   output logic                   is_completed,
   input  logic                   rst
);
   localparam int NW = $clog2(N_OUT + 1);
   state_t state;
   logic [NW-1:0] n;
   logic [N_TAPS*W-1:0] h;
   logic [N_SAMPLES*W-1:0] x;
   logic [N_TAPS*W-1:0] window;
   logic [W-1:0] y;
   // window tap k holds x[n-k], zero outside the signal block
   for (genvar k = 0; k < N_TAPS; k++) begin : g_win
      int i;
      assign i = int'(n) - k;
      assign window[k*W +: W] = (i >= 0 && i < N_SAMPLES) ? x[i*W +: W] : '0;
   end
   conv_mac_tree #(.N_TAPS(N_TAPS)) u_mac (.coeff(h), .window(window), .y(y));
   always_ff @(posedge clk) begin
      if (state == LOAD) begin
         h <= filter_coeff;
         x <= signal_in;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         n <= '0;
         conv_result <= '0;
         is_completed <= 1'b0;
      end else if (load) begin
         state <= LOAD;
         n <= '0;
         is_completed <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               n <= '0;
               state <= RUN;
            end
            RUN: begin
               conv_result[int'(n)*W +: W] <= y;
               n <= n + 1'b1;
               if (n == NW'(N_OUT - 1)) state <= DONE;
            end
            DONE: is_completed <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_convolve.sv
// tb_convolve: directed and random convolution runs checked against a direct-sum model
module tb_convolve;
   localparam int NT = 20;
   localparam int NS = 2401;
   localparam int NO = NT + NS - 1;
   localparam int W = 16;
   logic clk = 1'b0;
   logic rst, load;
   logic [NT*W-1:0] filter_coeff;
   logic [NS*W-1:0] signal_in;
   logic [NO*W-1:0] conv_result;
   logic is_completed;
   int checks = 0, errors = 0;
   logic signed [15:0] h [NT];
   logic signed [15:0] x [NS];
   logic [15:0] exp_y [NO];
   typedef struct {
      int kind;
      int idx;
      logic [15:0] val;
   } spot_t;
   spot_t spots [16];

   convolve dut (
      .clk(clk), .load(load), .filter_coeff(filter_coeff), .signal_in(signal_in),
      .conv_result(conv_result), .is_completed(is_completed), .rst(rst)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   task automatic check_result(input string name);
      int bad = 0, first = -1;
      for (int i = 0; i < NO; i++)
         if (conv_result[i*W +: W] !== exp_y[i]) begin
            if (first < 0) first = i;
            bad++;
         end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s: %0d bad slices, first y[%0d] got 0x%04h expected 0x%04h",
                  name, bad, first, conv_result[first*W +: W], exp_y[first]);
      end
   endtask

   task automatic set_kind(input int kind);
      for (int k = 0; k < NT; k++)
         h[k] = kind == 0 ? 16'sh4000 : kind == 1 ? (k == 0 ? 16'sh7fff : 16'sh0) :
                kind <= 3 ? 16'sh7fff : 16'($urandom);
      for (int i = 0; i < NS; i++)
         x[i] = kind == 0 ? (i == 0 ? 16'sh4000 : 16'sh0) : kind == 1 ? 16'(i) :
                kind == 2 ? 16'sh7fff : kind == 3 ? 16'sh8000 :
                kind == 4 ? 16'($urandom) : 16'($signed($urandom_range(0, 255)) - 128);
   endtask

   task automatic model();
      longint acc;
      for (int n = 0; n < NO; n++) begin
         acc = 0;
         for (int k = 0; k < NT; k++)
            if (n - k >= 0 && n - k < NS) acc += longint'(h[k]) * longint'(x[n-k]);
         acc = acc >>> 15;
         acc = acc > 32767 ? 32767 : acc < -32768 ? -32768 : acc;
         exp_y[n] = acc[15:0];
      end
   endtask

   task automatic start_load();
      @(negedge clk);
      load = 1'b1;
      for (int k = 0; k < NT; k++) filter_coeff[k*W +: W] = h[k];
      for (int i = 0; i < NS; i++) signal_in[i*W +: W] = x[i];
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int c;
      for (c = 0; c < 2500; c++) begin
         @(posedge clk);
         #1;
         if (is_completed) break;
      end
      check(name, c, NO + 1);
   endtask

   initial begin
      spots[0]  = '{0, 0, 16'h2000};    spots[1]  = '{0, 19, 16'h2000};
      spots[2]  = '{0, 20, 16'h0000};   spots[3]  = '{0, 2419, 16'h0000};
      spots[4]  = '{1, 0, 16'h0000};    spots[5]  = '{1, 1, 16'h0000};
      spots[6]  = '{1, 2, 16'h0001};    spots[7]  = '{1, 2400, 16'd2399};
      spots[8]  = '{1, 2401, 16'h0000}; spots[9]  = '{1, 2419, 16'h0000};
      spots[10] = '{2, 0, 16'h7ffe};    spots[11] = '{2, 1, 16'h7fff};
      spots[12] = '{2, 2418, 16'h7fff}; spots[13] = '{3, 0, 16'h8001};
      spots[14] = '{3, 1, 16'h8000};    spots[15] = '{3, 2418, 16'h8000};
      rst = 1'b1;
      load = 1'b0;
      filter_coeff = '0;
      signal_in = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NO; i++) exp_y[i] = '0;
      check_result("reset conv_result");
      check("reset is_completed", int'(is_completed), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int kind = 0; kind < 6; kind++) begin
         set_kind(kind);
         model();
         start_load();
         wait_done($sformatf("kind%0d done cycle", kind));
         check_result($sformatf("kind%0d result", kind));
         foreach (spots[s])
            if (spots[s].kind == kind)
               check($sformatf("kind%0d y[%0d]", kind, spots[s].idx),
                     int'(conv_result[spots[s].idx*W +: W]), int'(spots[s].val));
      end
      // operands change after DONE without load: nothing may move
      repeat (20) begin
         @(negedge clk);
         for (int k = 0; k < NT; k++) filter_coeff[k*W +: W] = 16'($urandom);
         for (int i = 0; i < NS; i++) signal_in[i*W +: W] = 16'($urandom);
      end
      #1;
      check_result("hold result");
      check("hold is_completed", int'(is_completed), 1);
      set_kind(4);
      start_load();
      repeat (1001) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NO; i++) exp_y[i] = '0;
      check_result("mid-run reset result");
      check("mid-run reset is_completed", int'(is_completed), 0);
      repeat (30) @(negedge clk);
      check_result("idle after reset result");
      check("idle after reset is_completed", int'(is_completed), 0);
      set_kind(5);
      model();
      start_load();
      wait_done("after reset done cycle");
      check_result("after reset result");
      set_kind(4);
      start_load();
      repeat (501) @(posedge clk);
      set_kind(5);
      model();
      start_load();
      wait_done("reload done cycle");
      check_result("reload result");
      set_kind(0);
      model();
      start_load();
      repeat (2420) @(posedge clk);
      @(negedge clk);
      load = 1'b1;
      @(posedge clk);
      #1;
      check("load at last sample is_completed", int'(is_completed), 0);
      @(negedge clk);
      load = 1'b0;
      wait_done("load at last sample done cycle");
      check_result("load at last sample result");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
